// File: rtl/ddc_param_core.sv
// Digital downconverter: NCO mixer, N-stage CIC with power-of-two decimation, round/saturate,
// and a 4-entry first-word-fall-through output buffer.
module ddc_param_core #(
  parameter int IN_W    = 16,
  parameter int NCO_W   = 16,
  parameter int OUT_W   = 24,
  parameter int CIC_N   = 3,
  parameter int MAX_DEC = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cfg_load,
  input  logic [3:0]              i_cfg_dec_log2,
  input  logic                    i_cfg_complex,
  input  logic signed [IN_W-1:0]  i_in_i,
  input  logic signed [IN_W-1:0]  i_in_q,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic signed [NCO_W-1:0] i_nco_cos,
  input  logic signed [NCO_W-1:0] i_nco_sin,
  output logic signed [OUT_W-1:0] o_out_i,
  output logic signed [OUT_W-1:0] o_out_q,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_sat_flag,
  output logic                    o_busy,
  output logic [1:0]              o_dbg_state
);
  localparam int KMAX   = $clog2(MAX_DEC);
  localparam int CNT_W  = (KMAX > 0) ? KMAX : 1;
  localparam int PW     = IN_W + NCO_W;
  localparam int PROD_W = PW + 1;
  localparam int ACC_W  = PROD_W + CIC_N * KMAX;
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FLUSH = 2'd1, S_RUN = 2'd2} state_t;
  state_t r_state, w_state_nxt;
  logic   r_fl_cnt;

  logic [3:0]              r_k;
  logic                    r_cplx;
  logic [CNT_W-1:0]        r_cnt;
  logic [2:0]              r_pend, r_fcnt;
  logic [1:0]              r_wp, r_rp;
  logic                    r_sat;
  logic                    r_s1_v, r_s1_dump, r_s2_v, r_s3_v, r_s4_v;
  logic signed [PROD_W-1:0] r_s1_i, r_s1_q;
  logic signed [ACC_W-1:0]  r_int_i [CIC_N];
  logic signed [ACC_W-1:0]  r_int_q [CIC_N];
  logic signed [ACC_W-1:0]  r_dly_i [CIC_N];
  logic signed [ACC_W-1:0]  r_dly_q [CIC_N];
  logic signed [ACC_W-1:0]  r_s3_i, r_s3_q;
  logic signed [OUT_W-1:0]  r_s4_i, r_s4_q;
  logic signed [OUT_W-1:0]  r_mem_i [4];
  logic signed [OUT_W-1:0]  r_mem_q [4];

  logic                     w_accept, w_dump, w_pop;
  logic [CNT_W:0]           w_rm1;
  logic [7:0]               w_shift;
  logic signed [PW-1:0]     w_xi, w_xq, w_c, w_s, w_ic, w_qs, w_qc, w_is;
  logic signed [PROD_W-1:0] w_mix_i, w_mix_q;
  logic signed [ACC_W-1:0]  w_int_nxt_i [CIC_N];
  logic signed [ACC_W-1:0]  w_int_nxt_q [CIC_N];
  logic signed [ACC_W-1:0]  w_comb_i [CIC_N];
  logic signed [ACC_W-1:0]  w_comb_q [CIC_N];
  logic [OUT_W:0]           w_norm_i, w_norm_q;

  // FSM: any cfg_load (re)starts a 2-cycle flush; IDLE waits for the first configuration.
  always_comb begin
    w_state_nxt = r_state;
    if (i_cfg_load) w_state_nxt = S_FLUSH;
    else if (r_state == S_FLUSH && r_fl_cnt) w_state_nxt = S_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_fl_cnt <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fl_cnt <= (r_state == S_FLUSH) & ~i_cfg_load;
    end
  end

  // r_pend counts decimated outputs already committed (in pipeline or buffer), so the buffer never overruns.
  assign o_in_ready  = (r_state == S_RUN) && (r_pend < 3'd4);
  assign o_busy      = (r_state == S_FLUSH);
  assign o_dbg_state = r_state;
  assign o_sat_flag  = r_sat;
  assign o_out_valid = (r_fcnt != 3'd0);
  assign o_out_i     = o_out_valid ? r_mem_i[r_rp] : '0;
  assign o_out_q     = o_out_valid ? r_mem_q[r_rp] : '0;
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;
  assign w_rm1       = ((CNT_W+1)'(1) << r_k) - (CNT_W+1)'(1);
  assign w_dump      = (r_cnt == w_rm1[CNT_W-1:0]);
  assign w_shift     = 8'(CIC_N) * {4'd0, r_k} + 8'(NCO_W - 1);

  // Mixer: multiply by e^-jwt; real mode ignores in_q.
  assign w_xi    = {{NCO_W{i_in_i[IN_W-1]}}, i_in_i};
  assign w_xq    = {{NCO_W{i_in_q[IN_W-1]}}, i_in_q};
  assign w_c     = {{IN_W{i_nco_cos[NCO_W-1]}}, i_nco_cos};
  assign w_s     = {{IN_W{i_nco_sin[NCO_W-1]}}, i_nco_sin};
  assign w_ic    = w_xi * w_c;
  assign w_qs    = w_xq * w_s;
  assign w_qc    = w_xq * w_c;
  assign w_is    = w_xi * w_s;
  assign w_mix_i = r_cplx ? {w_ic[PW-1], w_ic} + {w_qs[PW-1], w_qs} : {w_ic[PW-1], w_ic};
  assign w_mix_q = r_cplx ? {w_qc[PW-1], w_qc} - {w_is[PW-1], w_is} : -{w_is[PW-1], w_is};

  always_comb begin
    w_int_nxt_i[0] = r_int_i[0] + {{(ACC_W-PROD_W){r_s1_i[PROD_W-1]}}, r_s1_i};
    w_int_nxt_q[0] = r_int_q[0] + {{(ACC_W-PROD_W){r_s1_q[PROD_W-1]}}, r_s1_q};
    w_comb_i[0]    = r_int_i[CIC_N-1] - r_dly_i[0];
    w_comb_q[0]    = r_int_q[CIC_N-1] - r_dly_q[0];
    for (int j = 1; j < CIC_N; j++) begin
      w_int_nxt_i[j] = r_int_i[j] + w_int_nxt_i[j-1];
      w_int_nxt_q[j] = r_int_q[j] + w_int_nxt_q[j-1];
      w_comb_i[j]    = w_comb_i[j-1] - r_dly_i[j];
      w_comb_q[j]    = w_comb_q[j-1] - r_dly_q[j];
    end
  end

  // Round half up, arithmetic shift, then clip; MSB of the result flags a clip.
  function automatic logic [OUT_W:0] f_norm(input logic signed [ACC_W-1:0] a, input logic [7:0] sh);
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] y;
    rnd = {a[ACC_W-1], a} + ((ACC_W+1)'(1) << (sh - 8'd1));
    y   = rnd >>> sh;
    if (y > SAT_HI)      f_norm = {1'b1, SAT_HI[OUT_W-1:0]};
    else if (y < SAT_LO) f_norm = {1'b1, SAT_LO[OUT_W-1:0]};
    else                 f_norm = {1'b0, y[OUT_W-1:0]};
  endfunction

  assign w_norm_i = f_norm(r_s3_i, w_shift);
  assign w_norm_q = f_norm(r_s3_q, w_shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k <= '0; r_cplx <= 1'b0; r_cnt <= '0; r_pend <= '0; r_fcnt <= '0;
      r_wp <= '0; r_rp <= '0; r_sat <= 1'b0;
      r_s1_v <= 1'b0; r_s1_dump <= 1'b0; r_s2_v <= 1'b0; r_s3_v <= 1'b0; r_s4_v <= 1'b0;
      r_s1_i <= '0; r_s1_q <= '0; r_s3_i <= '0; r_s3_q <= '0; r_s4_i <= '0; r_s4_q <= '0;
      for (int j = 0; j < CIC_N; j++) begin
        r_int_i[j] <= '0; r_int_q[j] <= '0; r_dly_i[j] <= '0; r_dly_q[j] <= '0;
      end
      for (int j = 0; j < 4; j++) begin
        r_mem_i[j] <= '0; r_mem_q[j] <= '0;
      end
    end else if (i_cfg_load) begin
      r_k    <= (i_cfg_dec_log2 > 4'(KMAX)) ? 4'(KMAX) : i_cfg_dec_log2;
      r_cplx <= i_cfg_complex;
      r_cnt <= '0; r_pend <= '0; r_fcnt <= '0; r_wp <= '0; r_rp <= '0; r_sat <= 1'b0;
      r_s1_v <= 1'b0; r_s2_v <= 1'b0; r_s3_v <= 1'b0; r_s4_v <= 1'b0;
      for (int j = 0; j < CIC_N; j++) begin
        r_int_i[j] <= '0; r_int_q[j] <= '0; r_dly_i[j] <= '0; r_dly_q[j] <= '0;
      end
    end else begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1_i    <= w_mix_i;
        r_s1_q    <= w_mix_q;
        r_s1_dump <= w_dump;
        r_cnt     <= w_dump ? '0 : r_cnt + 1'b1;
      end
      r_s2_v <= r_s1_v & r_s1_dump;
      if (r_s1_v) begin
        for (int j = 0; j < CIC_N; j++) begin
          r_int_i[j] <= w_int_nxt_i[j];
          r_int_q[j] <= w_int_nxt_q[j];
        end
      end
      r_s3_v <= r_s2_v;
      if (r_s2_v) begin
        r_dly_i[0] <= r_int_i[CIC_N-1];
        r_dly_q[0] <= r_int_q[CIC_N-1];
        for (int j = 1; j < CIC_N; j++) begin
          r_dly_i[j] <= w_comb_i[j-1];
          r_dly_q[j] <= w_comb_q[j-1];
        end
        r_s3_i <= w_comb_i[CIC_N-1];
        r_s3_q <= w_comb_q[CIC_N-1];
      end
      r_s4_v <= r_s3_v;
      if (r_s3_v) begin
        r_s4_i <= w_norm_i[OUT_W-1:0];
        r_s4_q <= w_norm_q[OUT_W-1:0];
        if (w_norm_i[OUT_W] | w_norm_q[OUT_W]) r_sat <= 1'b1;
      end
      if (r_s4_v) begin
        r_mem_i[r_wp] <= r_s4_i;
        r_mem_q[r_wp] <= r_s4_q;
        r_wp          <= r_wp + 2'd1;
      end
      if (w_pop) r_rp <= r_rp + 2'd1;
      r_fcnt <= r_fcnt + {2'b0, r_s4_v} - {2'b0, w_pop};
      r_pend <= r_pend + {2'b0, w_accept & w_dump} - {2'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_ddc_param_core.sv
// Directed bench for ddc_param_core: a 24-bit and a 16-bit output instance share one stimulus.
module tb_ddc_param_core;
  logic clk = 1'b0;
  logic rst_n;
  logic cfg_load, cfg_complex, in_valid, out_ready;
  logic [3:0] cfg_dec_log2;
  logic signed [15:0] in_i, in_q, nco_cos, nco_sin;
  logic in_ready, out_valid, sat_flag, busy;
  logic signed [23:0] out_i, out_q;
  logic [1:0] dbg_state;
  logic in_ready16, out_valid16, sat16, busy16;
  logic signed [15:0] out_i16, out_q16;
  logic [1:0] dbg16;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;
  int acc_cyc = 0;
  logic signed [23:0] got_i[$];
  logic signed [23:0] got_q[$];
  int got_cyc[$];
  logic signed [15:0] g16_i[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddc_param_core u_dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_load(cfg_load), .i_cfg_dec_log2(cfg_dec_log2),
    .i_cfg_complex(cfg_complex), .i_in_i(in_i), .i_in_q(in_q), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_nco_cos(nco_cos), .i_nco_sin(nco_sin), .o_out_i(out_i),
    .o_out_q(out_q), .o_out_valid(out_valid), .i_out_ready(out_ready), .o_sat_flag(sat_flag),
    .o_busy(busy), .o_dbg_state(dbg_state));

  ddc_param_core #(.OUT_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .i_cfg_load(cfg_load), .i_cfg_dec_log2(cfg_dec_log2),
    .i_cfg_complex(cfg_complex), .i_in_i(in_i), .i_in_q(in_q), .i_in_valid(in_valid),
    .o_in_ready(in_ready16), .i_nco_cos(nco_cos), .i_nco_sin(nco_sin), .o_out_i(out_i16),
    .o_out_q(out_q16), .o_out_valid(out_valid16), .i_out_ready(out_ready), .o_sat_flag(sat16),
    .o_busy(busy16), .o_dbg_state(dbg16));

  // Handshakes are recorded on the falling edge; inputs only change just after a rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_i.push_back(out_i);
      got_q.push_back(out_q);
      got_cyc.push_back(cyc);
    end
    if (rst_n && out_valid16 && out_ready) g16_i.push_back(out_i16);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_i.delete(); got_q.delete(); got_cyc.delete(); g16_i.delete();
  endtask

  // Sets the sample and keeps in_valid high until accepted; caller drops valid with stop_in.
  task automatic send(input logic signed [15:0] si, input logic signed [15:0] sq,
                      input logic signed [15:0] c, input logic signed [15:0] s);
    in_i = si; in_q = sq; nco_cos = c; nco_sin = s; in_valid = 1'b1;
    for (int t = 0; t < 300 && !in_ready; t++) tick();
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    n_acc++;
    acc_cyc = cyc;
  endtask

  task automatic stop_in();
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n, input int budget);
    for (int t = 0; t < budget && got_i.size() < n; t++) tick();
    n_vec++;
    if (got_i.size() < n) begin
      n_err++;
      $display("FAIL wait_outs: got %0d outputs, required %0d", got_i.size(), n);
    end
  endtask

  task automatic do_cfg(input logic [3:0] k, input logic cplx);
    cfg_dec_log2 = k; cfg_complex = cplx; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_vec++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL flush_cycle%0d: busy=%0b in_ready=%0b required busy=1 in_ready=0", c, busy, in_ready);
      end
      tick();
    end
    n_vec++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 2'd2) begin
      n_err++;
      $display("FAIL flush_end: busy=%0b in_ready=%0b state=%0d required 0/1/2", busy, in_ready, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_load = 0; cfg_dec_log2 = 0; cfg_complex = 0; in_valid = 0;
    out_ready = 1'b1; in_i = 0; in_q = 0; nco_cos = 0; nco_sin = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || sat_flag !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: valid=%0b ready=%0b busy=%0b sat=%0b state=%0d required all 0",
               out_valid, in_ready, busy, sat_flag, dbg_state);
    end
    n_vec++;
    if (out_i !== 24'sd0 || out_q !== 24'sd0) begin
      n_err++;
      $display("FAIL reset_data: out_i=%0d out_q=%0d required 0", out_i, out_q);
    end
  endtask

  task automatic test_passthrough();
    do_cfg(4'd0, 1'b0);
    for (int n = 0; n < 2; n++) begin
      clear_q();
      send(16'sd1000, 16'sd0, 16'sh7FFF, 16'sd0);
      stop_in();
      wait_outs(1, 20);
      if (got_i.size() > 0) begin
        n_vec++;
        if (got_i[0] !== 24'sd1000 || got_q[0] !== 24'sd0) begin
          n_err++;
          $display("FAIL pass_data%0d: i=%0d q=%0d required 1000/0", n, got_i[0], got_q[0]);
        end
        n_vec++;
        if (got_cyc[0] - acc_cyc != 4) begin
          n_err++;
          $display("FAIL pass_latency%0d: %0d cycles required 4", n, got_cyc[0] - acc_cyc);
        end
      end
    end
  endtask

  task automatic test_decimate();
    do_cfg(4'd3, 1'b0);
    clear_q();
    for (int n = 0; n < 48; n++) send(16'sd1000, 16'sd0, 16'sh7FFF, 16'sd0);
    stop_in();
    wait_outs(6, 100);
    repeat (20) tick();
    n_vec++;
    if (got_i.size() != 6) begin
      n_err++;
      $display("FAIL dec_count: %0d outputs required 6", got_i.size());
    end
    for (int n = 3; n < 6 && n < got_i.size(); n++) begin
      n_vec++;
      if (got_i[n] < 24'sd999 || got_i[n] > 24'sd1001 || got_q[n] !== 24'sd0) begin
        n_err++;
        $display("FAIL dec_out%0d: i=%0d q=%0d required 1000+/-1 / 0", n, got_i[n], got_q[n]);
      end
    end
  endtask

  task automatic test_complex();
    do_cfg(4'd0, 1'b1);
    clear_q();
    send(16'sd1000, 16'sd0, 16'sd0, 16'sh7FFF);
    stop_in();
    wait_outs(1, 20);
    if (got_i.size() > 0) begin
      n_vec++;
      if (got_i[0] < -24'sd1 || got_i[0] > 24'sd1 || got_q[0] < -24'sd1001 || got_q[0] > -24'sd999) begin
        n_err++;
        $display("FAIL complex_mix: i=%0d q=%0d required 0 / -1000 (+/-1)", got_i[0], got_q[0]);
      end
    end
  endtask

  task automatic test_saturate();
    do_cfg(4'd0, 1'b0);
    clear_q();
    send(-16'sd32768, 16'sd0, -16'sd32768, 16'sd0);
    stop_in();
    wait_outs(1, 20);
    tick();
    n_vec++;
    if (g16_i.size() != 1 || g16_i[0] !== 16'sd32767 || sat16 !== 1'b1) begin
      n_err++;
      $display("FAIL sat16: n=%0d i=%0d sat=%0b required 1/32767/1", g16_i.size(),
               (g16_i.size() > 0) ? g16_i[0] : 16'sd0, sat16);
    end
    n_vec++;
    if (got_i.size() < 1 || got_i[0] !== 24'sd32768 || sat_flag !== 1'b0) begin
      n_err++;
      $display("FAIL sat24: i=%0d sat=%0b required 32768/0", (got_i.size() > 0) ? got_i[0] : 24'sd0, sat_flag);
    end
    do_cfg(4'd0, 1'b0);
    n_vec++;
    if (sat16 !== 1'b0) begin
      n_err++;
      $display("FAIL sat_clear: sat=%0b required 0", sat16);
    end
  endtask

  task automatic test_back_pressure();
    do_cfg(4'd0, 1'b0);
    out_ready = 1'b0;
    clear_q();
    n_acc = 0;
    fork
      begin
        for (int v = 1; v <= 10; v++) send(16'(v), 16'sd0, 16'sh7FFF, 16'sd0);
        stop_in();
      end
      begin
        repeat (20) tick();
        n_vec++;
        if (n_acc != 4 || out_valid !== 1'b1 || in_ready !== 1'b0 || got_i.size() != 0 || out_i !== 24'sd1) begin
          n_err++;
          $display("FAIL bp_full: acc=%0d valid=%0b ready=%0b popped=%0d head=%0d required 4/1/0/0/1",
                   n_acc, out_valid, in_ready, got_i.size(), out_i);
        end
        out_ready = 1'b1;
      end
    join
    wait_outs(10, 100);
    repeat (10) tick();
    n_vec++;
    if (got_i.size() != 10) begin
      n_err++;
      $display("FAIL bp_count: %0d outputs required 10", got_i.size());
    end
    for (int n = 0; n < 10 && n < got_i.size(); n++) begin
      n_vec++;
      if (got_i[n] !== 24'(n + 1)) begin
        n_err++;
        $display("FAIL bp_order%0d: got %0d required %0d", n, got_i[n], n + 1);
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    do_cfg(4'd0, 1'b0);
    clear_q();
    for (int n = 0; n < 3; n++) send(-16'sd32768, 16'sd0, -16'sd32768, 16'sd0);
    stop_in();
    repeat (8) tick();
    n_vec++;
    if (out_valid !== 1'b1 || sat16 !== 1'b1) begin
      n_err++;
      $display("FAIL flush_pre: valid=%0b sat16=%0b required 1/1", out_valid, sat16);
    end
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || sat16 !== 1'b0) begin
      n_err++;
      $display("FAIL flush_entry: valid=%0b busy=%0b sat16=%0b required 0/1/0", out_valid, busy, sat16);
    end
    tick();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL flush_second: busy=%0b required 1", busy);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_run: busy=%0b in_ready=%0b required 0/1", busy, in_ready);
    end
    out_ready = 1'b1;
    send(16'sd5, 16'sd0, 16'sh7FFF, 16'sd0);
    stop_in();
    wait_outs(1, 20);
    repeat (10) tick();
    n_vec++;
    if (got_i.size() != 1 || got_i[0] !== 24'sd5) begin
      n_err++;
      $display("FAIL flush_new: n=%0d first=%0d required 1/5", got_i.size(),
               (got_i.size() > 0) ? got_i[0] : 24'sd0);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_decimate();
    test_complex();
    test_saturate();
    test_back_pressure();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
